// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the irrigation-mode switch debouncer: channel
// mapping and the per-channel debounce state encoding.
package input_debouncer_pkg;

    localparam int CH_ASP = 0;
    localparam int CH_GOT = 1;
    localparam int CH_ADB = 2;
    localparam int NUM_CH = 3;

    // Gray-like ordering: each legal transition flips a single state bit.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        WAIT_LO   = 2'b10
    } deb_state_e;

    // True while a channel is qualifying a candidate level change.
    function automatic logic is_wait_state(input deb_state_e s);
        return (s == WAIT_HI) || (s == WAIT_LO);
    endfunction

    // True for the states in which the accepted level is high.
    function automatic logic is_high_state(input deb_state_e s);
        return (s == STABLE_HI) || (s == WAIT_LO);
    endfunction

endpackage

// File: rtl/input_debouncer_channel.sv
// Single-bit debounce channel: two-flop synchronizer, four-state debounce
// FSM with a consecutive-sample counter, and registered level/edge outputs.
module input_debouncer_channel
    import input_debouncer_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             busy_q,  busy_d;

    // Next-state logic: synchronizer shift, debounce FSM and counter, and the
    // registered copies of level, edge pulses and busy derived from next state.
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sync2_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            WAIT_HI: begin
                if (!sync2_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = CNT_ZERO;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync2_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            WAIT_LO: begin
                if (sync2_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = CNT_ZERO;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = CNT_ZERO;
            end
        endcase
        clean_d = is_high_state(state_d);
        busy_d  = is_wait_state(state_d);
    end

    // State register with asynchronous clear of every flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= CNT_ZERO;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign sw_clean = clean_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;
    assign busy     = busy_q;

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for the asp/got/adb irrigation-mode switches. Raw polarity is
// kept; each bit runs through its own independent debounce channel.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] sw_raw,
    output logic [NUM_CH-1:0] sw_clean,
    output logic [NUM_CH-1:0] sw_rise,
    output logic [NUM_CH-1:0] sw_fall,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [NUM_CH-1:0] busy_ch_s;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        input_debouncer_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_debounce_channel (
            .clock    (clock),
            .reset    (reset),
            .sw_raw   (sw_raw[ch]),
            .sw_clean (sw_clean[ch]),
            .sw_rise  (sw_rise[ch]),
            .sw_fall  (sw_fall[ch]),
            .busy     (busy_ch_s[ch])
        );
    end

    // Block is busy whenever any channel is qualifying a change.
    always_comb begin
        busy = |busy_ch_s;
    end

endmodule
